sram_sdp: RTL and testbench
===========================

Name: sram_sdp

Overview:
- Parametrised simple-dual-port synchronous SRAM: one write port and one read port, separate unidirectional data buses.
- Adds per-byte write enables, a configurable read pipeline depth and a selectable read-during-write policy.
- Adds a hardware clear-on-reset sweep with a busy flag.
- Sits wherever feature-map and weight buffers need concurrent fill and drain in the accelerator datapath.

Parameters:
DW, 8, data width in bits; must be a multiple of 8; NB = DW/8 byte lanes
AW, 14, address width; depth DP = 1 << AW words
RD_LAT, 1, read latency in cycles; legal values 1 or 2
RDW_MODE, 0, same-address read-during-write policy: 0 = read-first (old data), 1 = write-first (new data)
CLR_ON_RST, 1, 1 = zero every word after reset; 0 = no clear, contents undefined

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
busy  out  1  high while reset or clear sweep in progress; requests ignored
wr_en  in  1  write request, active high
wr_addr  in  AW  write address
wr_data  in  DW  write data
wr_be  in  NB  byte enables; bit i covers wr_data[8i+7:8i]
rd_en  in  1  read request, active high
rd_addr  in  AW  read address
rd_data  out  DW  read data, valid when rd_valid is high
rd_valid  out  1  single-cycle pulse per accepted read

Behaviour:
- Reset (rst high at an edge):
  - rd_valid = 0, rd_data = 0, all read pipeline valid bits = 0.
  - busy = 1, clear address counter = 0, FSM -> CLEAR (CLR_ON_RST=1) or READY (CLR_ON_RST=0).
  - busy stays 1 throughout rst.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each edge with rst low writes 0 to mem[clr_addr] and increments clr_addr.
  - The edge that writes address DP-1 moves the FSM to READY.
  - busy drops in the following cycle; the sweep takes exactly DP cycles after rst falls.
- READY:
  - busy = 0.
  - With CLR_ON_RST=0, READY is entered on the first edge with rst low; busy is 0 from the next cycle.
- rst reasserted mid-sweep: restart from address 0; no partial-state carry-over.
- Accepted operation = request high and busy low at the edge. While busy is high:
  - wr_en is dropped, with no memory change except the clear write.
  - rd_en is dropped, with no rd_valid.
- Write:
  - At an accepted edge, for each i with wr_be[i]=1, mem[wr_addr] byte i <= wr_data byte i.
  - Bytes with wr_be[i]=0 are unchanged.
  - wr_be = 0 is a legal no-op.
- Read timing:
  - Read accepted at edge N.
  - RD_LAT=1: rd_data and rd_valid update at edge N; visible for exactly one cycle.
  - RD_LAT=2: data passes through one extra register and appears after edge N+1.
  - Back-to-back reads on consecutive cycles give back-to-back rd_valid pulses in request order, with no bubbles.
- rd_data holds its last value when rd_valid is low; it changes only when a new read result is delivered.
- Read and write on different addresses in the same cycle: fully independent.
- Read and write on the same address in the same cycle:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the byte-merged word, i.e. wr_data bytes where wr_be=1, old bytes elsewhere.
  - The memory always ends holding the merged word.
- Address wrap: not applicable; addresses are AW bits and every value is legal.
- No X on rd_data after reset in any mode. With CLR_ON_RST=0, reads of never-written words are undefined; the bench must not check them.

Test Plan (DW=16, AW=4, DP=16 unless stated):
- Clear sweep: pulse rst for 2 cycles -> busy high through rst plus 16 cycles after its fall, then low. Read all 16 addresses -> every rd_data = 0x0000. Inject rst at sweep cycle 7 -> busy lasts another 16 cycles.
- Byte enables: write 0xABCD to addr 3 with be=2'b11, then 0x1200 with be=2'b10 -> read addr 3 returns 0x12CD. A write with be=2'b00 leaves 0x12CD.
- Latency/throughput: RD_LAT=1 and RD_LAT=2 runs; reads of addr 0..15 on consecutive cycles, preloaded with data = 0x0100+addr.
  - rd_valid is first high 1 (resp. 2) cycles after the first request.
  - 16 contiguous pulses with data 0x0100..0x010F in order.
  - rd_data holds 0x010F afterwards.
- Collision: mem[5]=0x1111; same cycle write 0x22FF be=2'b01 to addr 5 and read addr 5.
  - RDW_MODE=0 -> 0x1111.
  - RDW_MODE=1 -> 0x11FF.
  - A subsequent read returns 0x11FF in both modes.
- Busy gating: during the sweep, assert wr_en to addr 2 with data 0xFFFF, and rd_en -> no rd_valid. After busy falls, addr 2 reads 0x0000.
- CLR_ON_RST=0: busy falls one cycle after rst. Write then read addr 9 (0x5A5A) -> 0x5A5A with RD_LAT latency.

Source files
------------

// File: rtl/sram_sdp_if.sv
// -----------------------------------------------------------------------------
// sram_sdp_if
// Bus bundle for the simple-dual-port SRAM.
//   Write port : wr_en, wr_addr[AW], wr_data[DW], wr_be[NB]   (master -> slave)
//   Read port  : rd_en, rd_addr[AW]                           (master -> slave)
//                rd_data[DW], rd_valid                        (slave -> master)
//   Status     : busy, high during reset and the clear sweep  (slave -> master)
// The master modport is the requester; the slave modport is the memory.
// -----------------------------------------------------------------------------
interface sram_sdp_if #(
    parameter int DW = 8,
    parameter int AW = 14
);
    localparam int NB = DW / 8;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [NB-1:0] wr_be;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          busy;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  rd_data, rd_valid, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output rd_data, rd_valid, busy
    );
endinterface

// File: rtl/sram_sdp.sv
// -----------------------------------------------------------------------------
// sram_sdp
// Simple-dual-port synchronous SRAM: one write port with byte enables and one
// read port, configurable read latency (1 or 2), selectable same-address
// read-during-write policy and an optional zero-fill sweep after reset.
// Ports:
//   clk_i : clock, all logic on the rising edge
//   rst_i : synchronous active-high reset
//   bus   : sram_sdp_if.slave (write/read request buses, rd_data/rd_valid,
//           busy). Requests are dropped while busy is high.
// -----------------------------------------------------------------------------
module sram_sdp #(
    parameter int DW         = 8,
    parameter int AW         = 14,
    parameter int RD_LAT     = 1,
    parameter int RDW_MODE   = 0,
    parameter int CLR_ON_RST = 1
) (
    input  logic     clk_i,
    input  logic     rst_i,
    sram_sdp_if.slave bus
);
    localparam int NB = DW / 8;
    localparam int DP = 1 << AW;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
    localparam logic [0:0] ST_RESET = (CLR_ON_RST != 0) ? ST_CLEAR : ST_READY;

    logic [DW-1:0] mem_q [DP];

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic          busy_q;

    logic          clr_we_s;
    logic          wr_acc_s;
    logic          rd_acc_s;
    logic          collide_s;
    logic [DW-1:0] rd_word_s;
    logic [DW-1:0] merged_s;
    logic [DW-1:0] rd_sel_s;

    logic          s1_valid_q;
    logic [DW-1:0] s1_data_q;

    // rst_i is also gated in directly so no request slips through on the
    // very first reset edge, before busy_q has been forced high.
    assign clr_we_s  = (state_q == ST_CLEAR) && !rst_i;
    assign wr_acc_s  = bus.wr_en && !busy_q && !rst_i;
    assign rd_acc_s  = bus.rd_en && !busy_q && !rst_i;
    assign collide_s = wr_acc_s && (bus.wr_addr == bus.rd_addr);

    // Next-state logic for the clear sweep FSM.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + {{(AW-1){1'b0}}, 1'b1};
                if (clr_addr_q == {AW{1'b1}}) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                // Unknown encoding: fall back to a full re-clear.
                state_d    = ST_CLEAR;
                clr_addr_d = {AW{1'b0}};
            end
        endcase
    end

    // FSM, sweep counter and busy flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_RESET;
            clr_addr_q <= {AW{1'b0}};
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            // busy drops the cycle after the sweep writes the last word.
            busy_q     <= (state_d == ST_CLEAR);
        end
    end

    // Memory array: the clear sweep owns the write port while busy.
    always_ff @(posedge clk_i) begin
        if (clr_we_s) begin
            mem_q[clr_addr_q] <= {DW{1'b0}};
        end else if (wr_acc_s) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.wr_be[b]) begin
                    mem_q[bus.wr_addr][8*b +: 8] <= bus.wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read word selection including the write-first byte merge.
    always_comb begin
        rd_word_s = mem_q[bus.rd_addr];
        merged_s  = rd_word_s;
        for (int b = 0; b < NB; b++) begin
            if (bus.wr_be[b]) begin
                merged_s[8*b +: 8] = bus.wr_data[8*b +: 8];
            end else begin
                merged_s[8*b +: 8] = rd_word_s[8*b +: 8];
            end
        end
        if ((RDW_MODE == 1) && collide_s) begin
            rd_sel_s = merged_s;
        end else begin
            rd_sel_s = rd_word_s;
        end
    end

    // First read stage: data only moves on an accepted read so it holds.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= {DW{1'b0}};
        end else begin
            s1_valid_q <= rd_acc_s;
            if (rd_acc_s) begin
                s1_data_q <= rd_sel_s;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic          s2_valid_q;
            logic [DW-1:0] s2_data_q;

            // Second read stage, loaded only when stage one delivers.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= {DW{1'b0}};
                end else begin
                    s2_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        s2_data_q <= s1_data_q;
                    end
                end
            end

            assign bus.rd_valid = s2_valid_q;
            assign bus.rd_data  = s2_data_q;
        end else begin : g_lat1
            assign bus.rd_valid = s1_valid_q;
            assign bus.rd_data  = s1_data_q;
        end
    endgenerate

    assign bus.busy = busy_q;

endmodule

// File: tb/tb_sram_sdp.sv
// -----------------------------------------------------------------------------
// tb_sram_sdp
// Directed bench for sram_sdp with DW=16, AW=4. Three instances share one
// stimulus stream:
//   A : RD_LAT=1, RDW_MODE=0, CLR_ON_RST=1
//   B : RD_LAT=2, RDW_MODE=1, CLR_ON_RST=1
//   C : RD_LAT=1, RDW_MODE=1, CLR_ON_RST=0 (checked only on written words)
// -----------------------------------------------------------------------------
module tb_sram_sdp;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        wr_en, rd_en;
    logic [3:0]  wr_addr, rd_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;

    int n_cmp = 0;
    int n_err = 0;

    sram_sdp_if #(.DW(16), .AW(4)) ifa ();
    sram_sdp_if #(.DW(16), .AW(4)) ifb ();
    sram_sdp_if #(.DW(16), .AW(4)) ifc ();

    assign ifa.wr_en = wr_en;  assign ifb.wr_en = wr_en;  assign ifc.wr_en = wr_en;
    assign ifa.wr_addr = wr_addr; assign ifb.wr_addr = wr_addr; assign ifc.wr_addr = wr_addr;
    assign ifa.wr_data = wr_data; assign ifb.wr_data = wr_data; assign ifc.wr_data = wr_data;
    assign ifa.wr_be = wr_be;  assign ifb.wr_be = wr_be;  assign ifc.wr_be = wr_be;
    assign ifa.rd_en = rd_en;  assign ifb.rd_en = rd_en;  assign ifc.rd_en = rd_en;
    assign ifa.rd_addr = rd_addr; assign ifb.rd_addr = rd_addr; assign ifc.rd_addr = rd_addr;

    sram_sdp #(.DW(16), .AW(4), .RD_LAT(1), .RDW_MODE(0), .CLR_ON_RST(1)) u_a (
        .clk_i(clk), .rst_i(rst), .bus(ifa.slave));
    sram_sdp #(.DW(16), .AW(4), .RD_LAT(2), .RDW_MODE(1), .CLR_ON_RST(1)) u_b (
        .clk_i(clk), .rst_i(rst), .bus(ifb.slave));
    sram_sdp #(.DW(16), .AW(4), .RD_LAT(1), .RDW_MODE(1), .CLR_ON_RST(0)) u_c (
        .clk_i(clk), .rst_i(rst), .bus(ifc.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single read: A and C deliver after the request edge, B one edge later.
    task automatic read_one(input logic [3:0] a, input logic [15:0] ea,
                            input logic [15:0] eb, input logic [15:0] ec);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        chk("rd1_a_valid", {15'd0, ifa.rd_valid}, 16'd1);
        chk("rd1_a_data", ifa.rd_data, ea);
        chk("rd1_c_valid", {15'd0, ifc.rd_valid}, 16'd1);
        chk("rd1_c_data", ifc.rd_data, ec);
        chk("rd1_b_early", {15'd0, ifb.rd_valid}, 16'd0);
        tick();
        chk("rd1_b_valid", {15'd0, ifb.rd_valid}, 16'd1);
        chk("rd1_b_data", ifb.rd_data, eb);
        chk("rd1_a_pulse", {15'd0, ifa.rd_valid}, 16'd0);
        chk("rd1_a_hold", ifa.rd_data, ea);
    endtask

    // Reads of addresses 0..15 on consecutive cycles; expected word base+step*addr.
    task automatic read_stream(input logic [15:0] base, input logic [15:0] step, input bit chk_c);
        logic [15:0] e;
        logic [15:0] last;
        last = base + step * 16'd15;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                rd_en = 1'b1; rd_addr = i[3:0];
            end else begin
                rd_en = 1'b0;
            end
            tick();
            if (i < 16) begin
                e = base + step * 16'(i);
                chk("str_a_valid", {15'd0, ifa.rd_valid}, 16'd1);
                chk("str_a_data", ifa.rd_data, e);
                if (chk_c) begin
                    chk("str_c_data", ifc.rd_data, e);
                end
            end else begin
                chk("str_a_end", {15'd0, ifa.rd_valid}, 16'd0);
                chk("str_a_hold", ifa.rd_data, last);
            end
            if (i == 0) begin
                chk("str_b_first", {15'd0, ifb.rd_valid}, 16'd0);
            end else begin
                e = base + step * 16'(i - 1);
                chk("str_b_valid", {15'd0, ifb.rd_valid}, 16'd1);
                chk("str_b_data", ifb.rd_data, e);
            end
        end
        tick();
        chk("str_b_end", {15'd0, ifb.rd_valid}, 16'd0);
        chk("str_b_hold", ifb.rd_data, last);
        chk("str_a_hold2", ifa.rd_data, last);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = 4'd0; rd_addr = 4'd0; wr_data = 16'h0000; wr_be = 2'b00;

        // Reset for two cycles.
        tick(); tick();
        chk("rst_busy_a", {15'd0, ifa.busy}, 16'd1);
        chk("rst_busy_b", {15'd0, ifb.busy}, 16'd1);
        chk("rst_busy_c", {15'd0, ifc.busy}, 16'd1);
        chk("rst_valid_a", {15'd0, ifa.rd_valid}, 16'd0);
        chk("rst_valid_b", {15'd0, ifb.rd_valid}, 16'd0);
        chk("rst_data_a", ifa.rd_data, 16'h0000);
        chk("rst_data_b", ifb.rd_data, 16'h0000);
        chk("rst_data_c", ifc.rd_data, 16'h0000);
        rst = 1'b0;

        // Sweep: busy for 16 cycles; requests issued mid-sweep must be dropped.
        for (int k = 0; k < 16; k++) begin
            chk("sweep_busy_a", {15'd0, ifa.busy}, 16'd1);
            chk("sweep_busy_b", {15'd0, ifb.busy}, 16'd1);
            if (k == 0) chk("c_busy_first", {15'd0, ifc.busy}, 16'd1);
            if (k == 1) chk("c_busy_drop", {15'd0, ifc.busy}, 16'd0);
            if (k == 3) begin
                wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hFFFF; wr_be = 2'b11;
                rd_en = 1'b1; rd_addr = 4'd2;
            end
            tick();
            wr_en = 1'b0; rd_en = 1'b0;
            chk("gate_valid_a", {15'd0, ifa.rd_valid}, 16'd0);
            chk("gate_valid_b", {15'd0, ifb.rd_valid}, 16'd0);
        end
        chk("sweep_done_a", {15'd0, ifa.busy}, 16'd0);
        chk("sweep_done_b", {15'd0, ifb.busy}, 16'd0);

        // Every word zero, including addr 2 written while busy.
        read_stream(16'h0000, 16'h0000, 1'b0);

        // Reset injected at sweep cycle 7 restarts a full 16-cycle sweep.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < 7; k++) begin
            chk("inj_busy_pre", {15'd0, ifa.busy}, 16'd1);
            tick();
        end
        rst = 1'b1; tick();
        chk("inj_busy_rst", {15'd0, ifa.busy}, 16'd1);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("inj_busy_a", {15'd0, ifa.busy}, 16'd1);
            tick();
        end
        chk("inj_done_a", {15'd0, ifa.busy}, 16'd0);
        chk("inj_done_b", {15'd0, ifb.busy}, 16'd0);

        // Preload 0x0100+addr, then full-rate read stream.
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = i[3:0]; wr_data = 16'h0100 + 16'(i); wr_be = 2'b11;
            tick();
        end
        wr_en = 1'b0;
        read_stream(16'h0100, 16'h0001, 1'b1);

        // Byte enables.
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hABCD; wr_be = 2'b11; tick();
        wr_data = 16'h1200; wr_be = 2'b10; tick();
        wr_en = 1'b0;
        read_one(4'd3, 16'h12CD, 16'h12CD, 16'h12CD);
        wr_en = 1'b1; wr_data = 16'hFFFF; wr_be = 2'b00; tick();
        wr_en = 1'b0;
        read_one(4'd3, 16'h12CD, 16'h12CD, 16'h12CD);

        // Different-address read and write in the same cycle.
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h7777; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 4'd8;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("indep_a", ifa.rd_data, 16'h0108);
        chk("indep_c", ifc.rd_data, 16'h0108);
        tick();
        chk("indep_b", ifb.rd_data, 16'h0108);
        read_one(4'd7, 16'h7777, 16'h7777, 16'h7777);

        // Same-address collision.
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1111; wr_be = 2'b11; tick();
        wr_data = 16'h22FF; wr_be = 2'b01; rd_en = 1'b1; rd_addr = 4'd5;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("coll_a_rf", ifa.rd_data, 16'h1111);
        chk("coll_c_wf", ifc.rd_data, 16'h11FF);
        tick();
        chk("coll_b_wf", ifb.rd_data, 16'h11FF);
        read_one(4'd5, 16'h11FF, 16'h11FF, 16'h11FF);

        // Write then read addr 9 (covers the no-clear instance too).
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h5A5A; wr_be = 2'b11; tick();
        wr_en = 1'b0;
        read_one(4'd9, 16'h5A5A, 16'h5A5A, 16'h5A5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
